// File: rtl/lift_seq.sv
// ---------------------------------------------------------------------------
// lift_seq -- row sequencer for the lifting-wavelet datapath.
//
// Runs one lifting pass over a row of signed 16-bit samples held in a
// single-port SPRAM. For every updated index i it reads the left, centre and
// right neighbours (with symmetric extension at the row ends), presents the
// triple to an external lifting-step unit, and writes the unit's result back
// to base+i in place.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             single-cycle pass request, honoured only while idle
//   base, len         row start address and row length, latched with start
//   odd, fwd          pass parity and direction, latched with start
//   mem_addr/we/wdata SPRAM address, write enable, write data
//   mem_rdata         SPRAM read data, valid one cycle after its address
//   lift_l/s/r        left / centre / right samples to the lifting unit
//   lift_e_o, lift_f_i parity and direction flags to the lifting unit
//   lift_res          lifting-unit result
//   busy, done, err   pass status
//
// Handshake: start is a request pulse; it is accepted only in IDLE and is
// otherwise dropped without effect. Every accepted start produces exactly one
// done pulse; busy covers the cycles strictly between acceptance and done.
// err pulses together with done when the row is too short to process
// (len < 2), in which case the SPRAM is never touched.
// ---------------------------------------------------------------------------
module lift_seq #(
    parameter int ADDR_W   = 16,
    parameter int LIFT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic              odd,
    input  logic              fwd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       lift_l,
    output logic [15:0]       lift_s,
    output logic [15:0]       lift_r,
    output logic              lift_e_o,
    output logic              lift_f_i,
    input  logic [15:0]       lift_res,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LAT_W = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LIFT_LAT - 1);

    // Row indices carry one extra bit so that i+2 never wraps before it is
    // compared against the row length, even for rows of nearly 2^ADDR_W words.
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] IDX_TWO = (ADDR_W+1)'(2);

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        RD_S,
        RD_R,
        CAP,
        LIFT,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   idx;
    logic [LAT_W-1:0]  lat_cnt;

    logic [ADDR_W:0]   idx_nxt;
    logic [ADDR_W:0]   li_nxt;
    logic [ADDR_W:0]   ri_cur;
    logic [ADDR_W-1:0] first_li;

    assign idx_nxt = idx + IDX_TWO;
    // idx_nxt is always >= 2, so the left neighbour of the next index never
    // needs the i = 0 mirror.
    assign li_nxt  = idx_nxt - IDX_ONE;
    // Right edge mirrors onto i-1 when i is the last element of the row.
    assign ri_cur  = ((idx + IDX_ONE) >= len_r) ? (idx - IDX_ONE) : (idx + IDX_ONE);
    // First left neighbour: odd passes start at i=1 (left = 0); even passes
    // start at i=0 whose left neighbour mirrors to 1.
    assign first_li = odd ? '0 : ADDR_W'(1);

    // Outputs are registered: each transition loads the values the next
    // state must present, so the address is on the bus for the whole cycle
    // of the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_r    <= '0;
            len_r     <= '0;
            idx       <= '0;
            lat_cnt   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            lift_l    <= '0;
            lift_s    <= '0;
            lift_r    <= '0;
            lift_e_o  <= 1'b0;
            lift_f_i  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    err    <= 1'b0;
                    mem_we <= 1'b0;
                    if (start) begin
                        base_r   <= base;
                        len_r    <= {1'b0, len};
                        lift_e_o <= odd;
                        lift_f_i <= fwd;
                        if (len < ADDR_W'(2)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= RD_L;
                            busy     <= 1'b1;
                            idx      <= odd ? IDX_ONE : '0;
                            mem_addr <= base + first_li;
                        end
                    end
                end

                RD_L: begin
                    mem_addr <= base_r + idx[ADDR_W-1:0];
                    state    <= RD_S;
                end

                RD_S: begin
                    lift_l   <= mem_rdata;
                    mem_addr <= base_r + ri_cur[ADDR_W-1:0];
                    state    <= RD_R;
                end

                RD_R: begin
                    lift_s <= mem_rdata;
                    state  <= CAP;
                end

                CAP: begin
                    lift_r  <= mem_rdata;
                    lat_cnt <= '0;
                    state   <= LIFT;
                end

                LIFT: begin
                    if (lat_cnt == LAT_LAST) begin
                        mem_wdata <= lift_res;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_r + idx[ADDR_W-1:0];
                        state     <= WR;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                WR: begin
                    mem_we <= 1'b0;
                    idx    <= idx_nxt;
                    if (idx_nxt < len_r) begin
                        mem_addr <= base_r + li_nxt[ADDR_W-1:0];
                        state    <= RD_L;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_seq.sv
// ---------------------------------------------------------------------------
// tb_lift_seq -- self-checking bench for lift_seq.
//
// A behavioural SPRAM and lifting unit surround the DUT. A reference model
// computes, from the row contents, the expected neighbour addresses, sample
// triple and result of every updated index; each pass is then checked cycle
// by cycle against the pass schedule (5+LIFT_LAT cycles per index).
// ---------------------------------------------------------------------------
module tb_lift_seq;

    localparam int ADDR_W   = 16;
    localparam int LIFT_LAT = 1;
    localparam int P        = 5 + LIFT_LAT;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] len_in;
    logic              odd_in;
    logic              fwd_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic [15:0]       lift_l;
    logic [15:0]       lift_s;
    logic [15:0]       lift_r;
    logic              lift_e_o;
    logic              lift_f_i;
    logic [15:0]       lift_res;
    logic              busy;
    logic              done;
    logic              err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lift_seq #(
        .ADDR_W  (ADDR_W),
        .LIFT_LAT(LIFT_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base_in),
        .len      (len_in),
        .odd      (odd_in),
        .fwd      (fwd_in),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lift_l   (lift_l),
        .lift_s   (lift_s),
        .lift_r   (lift_r),
        .lift_e_o (lift_e_o),
        .lift_f_i (lift_f_i),
        .lift_res (lift_res),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // ---------------- lifting arithmetic (16-bit wrap) ----------------
    function automatic logic [15:0] lift_ref(input logic [15:0] l, input logic [15:0] s,
                                             input logic [15:0] r, input logic o, input logic f);
        logic signed [15:0] sum;
        logic signed [15:0] d;
        logic [15:0]        res;
        if (o) begin
            sum = l + r;
            d   = sum >>> 1;
        end else begin
            sum = l + r + 16'd2;
            d   = sum >>> 2;
        end
        if (f) res = o ? (s - d) : (s + d);
        else   res = o ? (s + d) : (s - d);
        return res;
    endfunction

    // ---------------- environment: SPRAM and lifting unit ----------------
    logic [15:0] tb_mem  [65536];
    logic [15:0] ref_mem [65536];
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    int          we_count;

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        else if (ld_en) tb_mem[ld_addr] <= ld_data;
        mem_rdata <= tb_mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) we_count = we_count + 1;
    end

    assign lift_res = lift_ref(lift_l, lift_s, lift_r, lift_e_o, lift_f_i);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] ra_l;
        logic [15:0] ra_s;
        logic [15:0] ra_r;
        logic [15:0] l;
        logic [15:0] s;
        logic [15:0] r;
        logic [15:0] res;
    } samp_t;

    samp_t       exp_q[$];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [15:0] q[$], input int i);
        if (i < q.size()) return {16'h0, q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // Reference model: walks the index set of one pass over ref_mem and
    // queues what each updated index must look like on the DUT pins.
    task automatic model_pass(input logic [15:0] b, input logic [15:0] n,
                              input logic o, input logic f);
        samp_t sm;
        int    li;
        int    ri;
        exp_q.delete();
        if (n < 2) return;
        for (int i = int'(o); i < int'(n); i += 2) begin
            li      = (i == 0) ? 1 : i - 1;
            ri      = (i + 1 >= int'(n)) ? i - 1 : i + 1;
            sm.ra_l = b + 16'(li);
            sm.ra_s = b + 16'(i);
            sm.ra_r = b + 16'(ri);
            sm.l    = ref_mem[sm.ra_l];
            sm.s    = ref_mem[sm.ra_s];
            sm.r    = ref_mem[sm.ra_r];
            sm.res  = lift_ref(sm.l, sm.s, sm.r, o, f);
            ref_mem[sm.ra_s] = sm.res;
            exp_q.push_back(sm);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic load_random_row(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) load_word(b + 16'(i), 16'($urandom_range(0, 65535)));
    endtask

    task automatic cmp_row(input string tag, input logic [15:0] b, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            check_val(tag, {16'h0, tb_mem[a]}, {16'h0, ref_mem[a]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_addr"}, {16'h0, mem_addr}, 32'h0);
        check_val({tag, "_we"}, {31'h0, mem_we}, 32'h0);
        check_val({tag, "_wdata"}, {16'h0, mem_wdata}, 32'h0);
        check_val({tag, "_lift_l"}, {16'h0, lift_l}, 32'h0);
        check_val({tag, "_lift_s"}, {16'h0, lift_s}, 32'h0);
        check_val({tag, "_lift_r"}, {16'h0, lift_r}, 32'h0);
        check_val({tag, "_flags"}, {30'h0, lift_e_o, lift_f_i}, 32'h0);
        check_val({tag, "_status"}, {29'h0, busy, done, err}, 32'h0);
    endtask

    // One full pass: start, then every cycle up to one past done is checked
    // against the model's per-index expectations and the pass schedule.
    task automatic run_pass(input string tag, input logic [15:0] b, input logic [15:0] n,
                            input logic o, input logic f, input logic inject);
        samp_t sm;
        int    k;
        int    ph;
        int    wc0;
        logic  err_exp;
        model_pass(b, n, o, f);
        k       = exp_q.size();
        err_exp = (n < 2);
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        start   = 1'b1;
        base_in = b;
        len_in  = n;
        odd_in  = o;
        fwd_in  = f;
        wc0     = we_count;
        for (int c = 0; c <= P * k + 1; c++) begin
            @(negedge clk);
            // Inputs other than start are scrambled during the pass; a start
            // pulse may be injected while the first index is in LIFT.
            start   = (inject && c == 4) ? 1'b1 : 1'b0;
            base_in = 16'($urandom_range(0, 65535));
            len_in  = 16'($urandom_range(0, 65535));
            odd_in  = 1'($urandom_range(0, 1));
            fwd_in  = 1'($urandom_range(0, 1));
            if (mem_we) wr_log.push_back(mem_addr);
            if (c < P * k) begin
                ph = c % P;
                sm = exp_q[c / P];
                check_val({tag, "_busy"}, {31'h0, busy}, 32'h1);
                check_val({tag, "_done_early"}, {30'h0, done, err}, 32'h0);
                if (ph <= 2) rd_log.push_back(mem_addr);
                if (ph == 0) check_val({tag, "_rd_l_addr"}, {16'h0, mem_addr}, {16'h0, sm.ra_l});
                if (ph == 1) check_val({tag, "_rd_s_addr"}, {16'h0, mem_addr}, {16'h0, sm.ra_s});
                if (ph == 2) check_val({tag, "_rd_r_addr"}, {16'h0, mem_addr}, {16'h0, sm.ra_r});
                if (ph == 4) begin
                    check_val({tag, "_lift_l"}, {16'h0, lift_l}, {16'h0, sm.l});
                    check_val({tag, "_lift_s"}, {16'h0, lift_s}, {16'h0, sm.s});
                    check_val({tag, "_lift_r"}, {16'h0, lift_r}, {16'h0, sm.r});
                    check_val({tag, "_flags"}, {30'h0, lift_e_o, lift_f_i}, {30'h0, o, f});
                end
                if (ph == P - 1) begin
                    check_val({tag, "_wr_we"}, {31'h0, mem_we}, 32'h1);
                    check_val({tag, "_wr_addr"}, {16'h0, mem_addr}, {16'h0, sm.ra_s});
                    check_val({tag, "_wr_data"}, {16'h0, mem_wdata}, {16'h0, sm.res});
                end else begin
                    check_val({tag, "_no_we"}, {31'h0, mem_we}, 32'h0);
                end
            end else if (c == P * k) begin
                check_val({tag, "_done"}, {30'h0, done, err}, {30'h0, 1'b1, err_exp});
                check_val({tag, "_done_busy"}, {31'h0, busy}, 32'h0);
                check_val({tag, "_done_we"}, {31'h0, mem_we}, 32'h0);
            end else begin
                check_val({tag, "_idle"}, {29'h0, busy, done, err}, 32'h0);
                check_val({tag, "_idle_we"}, {31'h0, mem_we}, 32'h0);
            end
        end
        start = 1'b0;
        check_val({tag, "_write_count"}, 32'(we_count - wc0), 32'(k));
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] s1_wa  [4] = '{16'h0001, 16'h0003, 16'h0005, 16'h0007};
    logic [15:0] s5_ra  [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    logic [15:0] s5_wa  [2] = '{16'hFFFF, 16'h0001};

    initial begin
        logic [15:0] rb;
        logic [15:0] rl;
        int          wc0;
        n_checks = 0;
        n_fail   = 0;
        we_count = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        base_in  = '0;
        len_in   = '0;
        odd_in   = 1'b0;
        fwd_in   = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Odd forward pass over a ramp.
        for (int i = 0; i < 8; i++) load_word(16'(i), 16'(10 * i));
        run_pass("odd_fwd", 16'h0000, 16'd8, 1'b1, 1'b1, 1'b0);
        check_val("odd_fwd_x1", {16'h0, tb_mem[1]}, 32'd0);
        check_val("odd_fwd_x3", {16'h0, tb_mem[3]}, 32'd0);
        check_val("odd_fwd_x5", {16'h0, tb_mem[5]}, 32'd0);
        check_val("odd_fwd_x7", {16'h0, tb_mem[7]}, 32'd10);
        check_val("odd_fwd_x6", {16'h0, tb_mem[6]}, 32'd60);
        check_val("odd_fwd_nwr", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_val("odd_fwd_waddr", q_at(wr_log, i), {16'h0, s1_wa[i]});

        // Even forward pass on that result, with a stray start during LIFT.
        run_pass("even_fwd", 16'h0000, 16'd8, 1'b0, 1'b1, 1'b1);
        check_val("even_fwd_x0", {16'h0, tb_mem[0]}, 32'd0);
        check_val("even_fwd_x2", {16'h0, tb_mem[2]}, 32'd20);
        check_val("even_fwd_x4", {16'h0, tb_mem[4]}, 32'd40);
        check_val("even_fwd_x6", {16'h0, tb_mem[6]}, 32'd63);
        check_val("even_fwd_x7", {16'h0, tb_mem[7]}, 32'd10);
        check_val("even_fwd_x1", {16'h0, tb_mem[1]}, 32'd0);

        // Two-element row: both neighbours of x0 mirror to x1.
        load_word(16'h0100, 16'd100);
        load_word(16'h0101, 16'hFFFC);
        run_pass("len2", 16'h0100, 16'd2, 1'b0, 1'b1, 1'b0);
        check_val("len2_x0", {16'h0, tb_mem[16'h0100]}, 32'd98);
        check_val("len2_x1", {16'h0, tb_mem[16'h0101]}, 32'h0000FFFC);

        // Too-short rows.
        run_pass("len1", 16'h0020, 16'd1, 1'b0, 1'b1, 1'b0);
        run_pass("len0", 16'h0030, 16'd0, 1'b1, 1'b0, 1'b0);

        // Address wrap at the top of the address space.
        load_random_row(16'hFFFE, 4);
        run_pass("wrap", 16'hFFFE, 16'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) check_val("wrap_raddr", q_at(rd_log, i), {16'h0, s5_ra[i]});
        for (int i = 0; i < 2; i++) check_val("wrap_waddr", q_at(wr_log, i), {16'h0, s5_wa[i]});
        cmp_row("wrap_row", 16'hFFFE, 4);

        // Reset in the middle of a pass (during RD_S).
        load_random_row(16'h0200, 6);
        @(negedge clk);
        start   = 1'b1;
        base_in = 16'h0200;
        len_in  = 16'd6;
        odd_in  = 1'b1;
        fwd_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        wc0 = we_count;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_val("midreset_busy", {31'h0, busy}, 32'h0);
        end
        check_val("midreset_writes", 32'(we_count - wc0), 32'h0);
        cmp_row("midreset_row", 16'h0200, 6);

        // Randomized passes.
        for (int t = 0; t < 24; t++) begin
            rb = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF4 + $urandom_range(0, 11))
                                             : 16'($urandom_range(0, 65535));
            rl = 16'($urandom_range(0, 12));
            load_random_row(rb, int'(rl));
            run_pass("rand", rb, rl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            cmp_row("rand_row", rb, int'(rl));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lift_seq.md
# lift_seq

Row sequencer for the lifting-wavelet datapath. Reads one row of signed 16-bit samples from single-port SPRAM, presents each left/centre/right triple to a lifting-step unit, and writes the unit's result back in place. It sits between the SPRAM and the lifting unit and runs one lifting pass per start command. The UART command path uses it to launch a pass.

## Interface
- ADDR_W, 16, SPRAM word-address width.
- LIFT_LAT, 1, lifting-unit latency in cycles from triple valid to result valid; minimum 1.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pass request; sampled only in IDLE
- base  in  ADDR_W  address of row element 0; sampled with start
- len  in  ADDR_W  row length N; sampled with start
- odd  in  1  pass parity: 1 updates odd indices, 0 updates even indices
- fwd  in  1  1 = forward transform, 0 = inverse; forwarded to the lifting unit
- mem_addr  out  ADDR_W  SPRAM address
- mem_we  out  1  SPRAM write enable
- mem_wdata  out  16  SPRAM write data
- mem_rdata  in  16  SPRAM read data, valid the cycle after its address is driven
- lift_l, lift_s, lift_r  out  16 each  signed left, centre and right samples to the lifting unit
- lift_e_o  out  1  parity flag to the lifting unit (equals odd)
- lift_f_i  out  1  direction flag to the lifting unit (equals fwd)
- lift_res  in  16  signed lifting result
- busy  out  1  high from the first cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  one-cycle pulse coincident with done when len < 2

## Operation
- States: IDLE, RD_L, RD_S, RD_R, CAP, LIFT, WR, DONE.
- IDLE: start=1 latches base, len, odd and fwd.
  - len < 2: go to DONE with err=1. No memory access occurs.
  - Otherwise set i = odd ? 1 : 0 and go to RD_L. If odd=1 and len < 2 there is no odd index; this case is already covered by the len < 2 rule.
- Index set: i, i+2, ... while i < N.
- Symmetric extension:
  - li = i-1, except li = i+1 when i = 0.
  - ri = i+1, except ri = i-1 when i+1 ≥ N.
- Per-sample sequence:
  - RD_L: drive addr base+li.
  - RD_S: drive addr base+i; capture l from mem_rdata.
  - RD_R: drive addr base+ri; capture s.
  - CAP: capture r.
  - LIFT: lift_l/s/r hold the captured values for LIFT_LAT cycles. lift_res is captured on the last of these cycles.
  - WR: mem_addr = base+i, mem_we = 1, mem_wdata = captured result; i += 2. Next state is RD_L if i < N, else DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- All address arithmetic is modulo 2^ADDR_W; base+i wraps without error.
- Triple outputs hold their last values between samples. They are meaningful only in LIFT.
- start outside IDLE is ignored with no side effect.
- lift_e_o and lift_f_i are constant for the whole pass.
- Reference lifting model for verification:
  - odd/fwd: res = s − ((l+r)>>>1)
  - even/fwd: res = s + ((l+r+2)>>>2)
  - inverse passes use the opposite signs.
  - Arithmetic is 16-bit two's complement with wrap; the sequencer never alters data.

## Timing
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: mem_addr, mem_we, mem_wdata, lift_l/s/r, lift_e_o, lift_f_i, busy, done, err.
- Reset asserted mid-pass aborts immediately; no further writes occur after reset release.
- Cycle 0 is the edge that samples start.
  - Each sample takes 5+LIFT_LAT cycles (6 at the default).
  - With K updated indices, done is high in cycle (5+LIFT_LAT)·K+1.
  - For the len < 2 error, done and err are high in cycle 1.
- Exactly one mem_we cycle per updated index. No write in any other state.
- Pass throughput at default parameters: 6 cycles per updated sample.

## Test plan
- Odd forward pass: len=8, base=0, x = 0,10,20,…,70, LIFT_LAT=1.
  - Required: x1=x3=x5=0 and x7=10 (right extension uses x6); even indices unchanged.
  - Exactly 4 writes, to addresses 1,3,5,7; done in cycle 25.
- Even forward pass on the result of the previous scenario (0,0,20,0,40,0,60,10).
  - Required: x0 uses l=r=x1, giving x0=0; x2=20, x4=40, x6=63.
  - Odd indices unchanged.
- len=2, odd=0, x = 100,−4.
  - Required: one write to address 0 with l=r=−4, giving 100+((−8+2)>>>2) = 98.
- len=1 → done and err both high in cycle 1; mem_we never asserted.
- base=0xFFFE, len=4, odd=1.
  - Required read addresses, in order: 0xFFFE, 0xFFFF, 0x0000, then 0x0000, 0x0001, 0x0000.
  - Writes to 0xFFFF then 0x0001.
- start pulsed during LIFT is ignored and the pass completes unchanged.
- rst_n pulsed low during RD_S → all outputs 0 immediately; no mem_we after release; busy=0.
